multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore-style FSM that sequences the multicycle MIPS datapath: PC adder, sign extend,
//  shift-left-2, operand/PC-source muxes, register file, ALU and the shared memory.
//  Drives all mux selects and write strobes. Stalls on a memory ready handshake and
//  flags memory timeouts and illegal opcodes. Counts retired instructions.
// PARAMETERS
//  WAIT_LIMIT  15  max cycles a memory state waits for mem_ready before bus_error
//  CNT_WIDTH   32  width of retired-instruction counter
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  opcode        in   6   instr[31:26] from IR (valid from DECODE onward)
//  zero          in   1   ALU zero flag (used in BRANCH)
//  mem_ready     in   1   memory completes current read/write this cycle
//  pc_write      out  1   unconditional PC load
//  pc_write_cond out  1   PC load if zero (beq)
//  i_or_d        out  1   memory address mux: 0=PC, 1=ALUOut
//  mem_read      out  1   memory read request
//  mem_write     out  1   memory write request
//  ir_write      out  1   IR load
//  mem_to_reg    out  1   writeback mux: 0=ALUOut, 1=MDR
//  reg_dst       out  1   dest reg mux: 0=rt, 1=rd
//  reg_write     out  1   register file write
//  alu_src_a     out  1   0=PC, 1=A
//  alu_src_b     out  2   00=B, 01=4, 10=sign_ext, 11=sign_ext<<2
//  alu_op        out  2   00=add, 01=sub, 10=funct-decoded
//  pc_source     out  2   00=ALU, 01=ALUOut, 10=jump target
//  done          out  1   1-cycle pulse when an instruction retires
//  illegal_op    out  1   1-cycle pulse, unknown opcode in DECODE
//  bus_error     out  1   1-cycle pulse, memory wait exceeded WAIT_LIMIT
//  instr_count   out  CNT_WIDTH  retired-instruction count, wraps to 0
// BEHAVIOUR
//  - Reset: state=FETCH, wait counter=0, instr_count=0; while rst=1 every output is 0.
//  - Outputs decode from state only, except strobes gated by mem_ready as stated.
//  - States and transitions (opcodes: R=000000 lw=100011 sw=101011 beq=000100
//    j=000010 addi=001000):
//    FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00,
//      pc_source=00; ir_write and pc_write only when mem_ready=1 -> DECODE; else hold.
//    DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next state by opcode:
//      lw/sw->MEM_ADDR, R->R_EXEC, beq->BRANCH, j->JUMP, addi->I_EXEC,
//      other->FETCH with illegal_op=1 (not counted as retired).
//    MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_READ (lw) / MEM_WRITE (sw).
//    MEM_READ: mem_read=1, i_or_d=1; mem_ready -> MEM_WB; else hold.
//    MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; done -> FETCH.
//    MEM_WRITE: mem_write=1, i_or_d=1; mem_ready -> FETCH with done; else hold.
//    R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
//    R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; done -> FETCH.
//    I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> I_WB.
//    I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; done -> FETCH.
//    BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01;
//      done -> FETCH.
//    JUMP: pc_write=1, pc_source=10; done -> FETCH.
//  - Latency (mem_ready tied 1): lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
//  - Wait counter: cleared on entry to FETCH/MEM_READ/MEM_WRITE and on leaving them;
//    increments each held cycle. When the counter = WAIT_LIMIT and mem_ready=0:
//    bus_error=1, all strobes 0 that cycle, and the next state is FETCH (PC not advanced;
//    instruction abandoned, not counted).
//  - mem_ready in a non-memory state is ignored.
//  - done and instr_count+1 happen in the same cycle; the counter wraps at 2^CNT_WIDTH.
//  - rst asserted mid-instruction: the next cycle is FETCH with counters cleared and
//    no partial strobes.
// STRUCTURE
//  - Shared include cpu_defs.vh: state encodings (4-bit), opcode constants,
//    alu_op / alu_src_b / pc_source codes; also used by alu_control and the datapath.
//  - One sub-module: mem_wait_timer (counter, clear/enable, timeout flag vs WAIT_LIMIT).
//  - The rest is one next-state always block, one state register, and a combinational
//    output decode.
// TESTING
//  - Reset with mem_ready=1, rst held 3 cycles: all outputs 0. Release -> FETCH with
//    mem_read=1, ir_write=1, pc_write=1.
//  - R-type (opcode 000000), mem_ready=1: states FETCH,DECODE,R_EXEC,R_WB. reg_dst=1
//    and reg_write=1 in cycle 4, done once, instr_count 0->1.
//  - lw with mem_ready low 3 cycles in MEM_READ: 8 cycles total, reg_write with
//    mem_to_reg=1 once. sw with 2 wait cycles: mem_write held 3 cycles, reg_write never.
//  - beq, zero=1 and zero=0: pc_write_cond=1 and pc_source=01 in BRANCH both times.
//    j: pc_write=1 and pc_source=10. Each completes in 3 cycles.
//  - Opcode 111111: illegal_op pulses in DECODE, back to FETCH, instr_count unchanged.
//  - mem_ready stuck 0 in FETCH: bus_error on cycle WAIT_LIMIT+1 (16), then FETCH again.
//    rst pulse during MEM_READ -> FETCH and instr_count=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes
// and the mux/ALU select codes also understood by alu_control and the datapath.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that issue a memory access and may stall on mem_ready.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Stall-cycle counter for memory states. Counts while enabled, clears
// otherwise, and flags when the count has reached WAIT_LIMIT.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, then increment on a held stall cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CW'(WAIT_LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Moore controller for the multicycle MIPS datapath: sequences fetch,
// decode, execute, memory and writeback, stalls on mem_ready, raises
// bus_error on a memory timeout and illegal_op on unknown opcodes, and
// counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic                 done,
  output logic                 illegal_op,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] instr_count
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mem_state;
  logic                 wait_en;
  logic                 timeout;
  logic                 to_err;
  logic                 unused_zero;

  // The branch decision (zero AND pc_write_cond) is made in the datapath.
  assign unused_zero = zero;

  // A stall cycle is a memory state without mem_ready; the timer runs only
  // on stalls and clears on any other cycle, which covers entry and exit.
  assign mem_state = is_mem_wait_state(state_q);
  assign wait_en   = mem_state && !mem_ready && !timeout;
  assign to_err    = mem_state && !mem_ready && timeout;

  mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!wait_en),
    .en      (wait_en),
    .timeout (timeout)
  );

  // Next-state logic; a memory timeout abandons the instruction to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEM_WRITE: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB,
      S_R_WB,
      S_I_WB,
      S_BRANCH,
      S_JUMP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Output decode from state; write strobes in memory states also follow
  // mem_ready, and everything is forced low while rst is asserted.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    done          = 1'b0;
    illegal_op    = 1'b0;
    bus_error     = 1'b0;
    if (!rst) begin
      bus_error = to_err;
      case (state_q)
        S_FETCH: begin
          mem_read  = !to_err;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_SEXT_SH2;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default:                                       illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR, S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_SEXT;
        end
        S_MEM_READ: begin
          mem_read = !to_err;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          done       = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = !to_err;
          i_or_d    = 1'b1;
          done      = mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          done      = 1'b1;
        end
        S_I_WB: begin
          reg_write = 1'b1;
          done      = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          done          = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
          done      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Retired count advances together with done and wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (done) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign instr_count = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes the
// expected outputs, a negedge monitor pops and compares them.
module tb_multicycle_control;

  localparam int WAIT_LIMIT = 15;
  localparam int CNT_WIDTH  = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [5:0]           opcode = 6'd0;
  logic                 zero = 1'b0;
  logic                 mem_ready = 1'b1;
  logic                 pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]           alu_src_b, alu_op, pc_source;
  logic                 done, illegal_op, bus_error;
  logic [CNT_WIDTH-1:0] instr_count;

  multicycle_control #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .done          (done),
    .illegal_op    (illegal_op),
    .bus_error     (bus_error),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       done;
    logic       illegal_op;
    logic       bus_error;
  } outs_t;

  typedef enum {
    P_RST, P_FETCH, P_DECODE, P_DECODE_ILL, P_MADDR, P_MREAD, P_MWB,
    P_MWRITE, P_REXEC, P_RWB, P_IEXEC, P_IWB, P_BRANCH, P_JUMP
  } ph_t;

  typedef struct {
    outs_t                o;
    logic [CNT_WIDTH-1:0] cnt;
    string                tag;
  } exp_t;

  exp_t                 sb[$];
  logic [CNT_WIDTH-1:0] exp_cnt = '0;
  int                   n_vec = 0;
  int                   n_err = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference outputs for each phase of the instruction cycle.
  function automatic outs_t model(input ph_t ph, input logic mr, input logic to);
    outs_t o;
    o = '0;
    case (ph)
      P_FETCH:      begin o.mem_read = !to; o.alu_src_b = 2'b01; o.ir_write = mr;
                          o.pc_write = mr; o.bus_error = to; end
      P_DECODE:     o.alu_src_b = 2'b11;
      P_DECODE_ILL: begin o.alu_src_b = 2'b11; o.illegal_op = 1'b1; end
      P_MADDR,
      P_IEXEC:      begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      P_MREAD:      begin o.mem_read = !to; o.i_or_d = 1'b1; o.bus_error = to; end
      P_MWB:        begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.done = 1'b1; end
      P_MWRITE:     begin o.mem_write = !to; o.i_or_d = 1'b1; o.done = mr; o.bus_error = to; end
      P_REXEC:      begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      P_RWB:        begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.done = 1'b1; end
      P_IWB:        begin o.reg_write = 1'b1; o.done = 1'b1; end
      P_BRANCH:     begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
                          o.pc_source = 2'b01; o.done = 1'b1; end
      P_JUMP:       begin o.pc_write = 1'b1; o.pc_source = 2'b10; o.done = 1'b1; end
      default:      o = '0;
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs and queue what the controller must show.
  task automatic step(input ph_t ph, input logic mr, input logic [5:0] op,
                      input logic z, input logic r, input logic to, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mem_ready = mr; opcode = op; zero = z;
    e.o   = r ? '0 : model(ph, mr, to);
    if (r) exp_cnt = '0;
    e.cnt = exp_cnt;
    e.tag = tag;
    sb.push_back(e);
    if (e.o.done) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic s(input ph_t ph, input logic mr, input logic [5:0] op, input string tag);
    step(ph, mr, op, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic run_jump(input string tag);
    s(P_FETCH, 1'b1, J, tag);
    s(P_DECODE, 1'b1, J, tag);
    s(P_JUMP, 1'b1, J, tag);
  endtask

  // Compare observed outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t  e;
      outs_t got;
      e   = sb.pop_front();
      got = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
              pc_source, done, illegal_op, bus_error};
      check_eq({e.tag, "/outs"}, 32'(got), 32'(e.o));
      check_eq({e.tag, "/cnt"}, 32'(instr_count), 32'(e.cnt));
    end
  end

  initial begin
    // reset held three cycles with mem_ready high
    for (int i = 0; i < 3; i++) step(P_RST, 1'b1, R, 1'b0, 1'b1, 1'b0, "reset");

    // R-type, mem_ready noise in non-memory states is ignored
    s(P_FETCH, 1'b1, R, "r_fetch");
    s(P_DECODE, 1'b0, R, "r_decode");
    s(P_REXEC, 1'b0, R, "r_exec");
    s(P_RWB, 1'b1, R, "r_wb");

    // lw with three stall cycles in MEM_READ
    s(P_FETCH, 1'b1, LW, "lw_fetch");
    s(P_DECODE, 1'b1, LW, "lw_decode");
    s(P_MADDR, 1'b1, LW, "lw_addr");
    for (int i = 0; i < 3; i++) s(P_MREAD, 1'b0, LW, "lw_stall");
    s(P_MREAD, 1'b1, LW, "lw_read");
    s(P_MWB, 1'b1, LW, "lw_wb");

    // sw with two stall cycles in MEM_WRITE
    s(P_FETCH, 1'b1, SW, "sw_fetch");
    s(P_DECODE, 1'b1, SW, "sw_decode");
    s(P_MADDR, 1'b1, SW, "sw_addr");
    for (int i = 0; i < 2; i++) s(P_MWRITE, 1'b0, SW, "sw_stall");
    s(P_MWRITE, 1'b1, SW, "sw_write");

    // addi
    s(P_FETCH, 1'b1, ADDI, "addi_fetch");
    s(P_DECODE, 1'b1, ADDI, "addi_decode");
    s(P_IEXEC, 1'b1, ADDI, "addi_exec");
    s(P_IWB, 1'b1, ADDI, "addi_wb");

    // beq taken and not taken: controller outputs identical
    for (int z = 1; z >= 0; z--) begin
      step(P_FETCH, 1'b1, BEQ, 1'(z), 1'b0, 1'b0, "beq_fetch");
      step(P_DECODE, 1'b1, BEQ, 1'(z), 1'b0, 1'b0, "beq_decode");
      step(P_BRANCH, 1'b1, BEQ, 1'(z), 1'b0, 1'b0, "beq_branch");
    end

    run_jump("j");

    // illegal opcode: pulse in DECODE, straight back to FETCH, not retired
    s(P_FETCH, 1'b1, BAD, "ill_fetch");
    s(P_DECODE_ILL, 1'b1, BAD, "ill_decode");

    // mem_ready stuck low in FETCH: timeout on the 16th cycle
    for (int i = 0; i < WAIT_LIMIT; i++) s(P_FETCH, 1'b0, J, "stuck_wait");
    step(P_FETCH, 1'b0, J, 1'b0, 1'b0, 1'b1, "stuck_timeout");
    run_jump("after_timeout");

    // more jumps so the narrow counter wraps through zero
    run_jump("wrap_a");
    run_jump("wrap_b");

    // reset pulse in the middle of a load
    s(P_FETCH, 1'b1, LW, "rstmid_fetch");
    s(P_DECODE, 1'b1, LW, "rstmid_decode");
    s(P_MADDR, 1'b1, LW, "rstmid_addr");
    s(P_MREAD, 1'b0, LW, "rstmid_read");
    step(P_RST, 1'b0, LW, 1'b0, 1'b1, 1'b0, "rstmid_rst");
    s(P_FETCH, 1'b1, R, "post_rst_fetch");
    s(P_DECODE, 1'b1, R, "post_rst_decode");
    s(P_REXEC, 1'b1, R, "post_rst_exec");
    s(P_RWB, 1'b1, R, "post_rst_wb");
    s(P_FETCH, 1'b0, R, "post_rst_count");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check_eq("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
